ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) from the PicoBlaze to the attached keyboard over the shared open-drain PS2C/PS2D lines. It complements the keyboard receiver, which only handles device-to-host traffic. It sits beside the receiver in the top level and takes the byte from a PicoBlaze output port. While it owns the bus, it asserts `rx_inhibit` so the receiver ignores the clocks the device generates.

---
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard over
// the open-drain PS2C/PS2D pair and reports ok / timeout / no-ACK on completion.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       ps2c_low,
  output logic       ps2d_low,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic [1:0] err_code
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(FILTER_LEN + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Bit 0 carries PS2C, bit 1 carries PS2D through the conditioning path.
  logic [1:0]    w_lines;
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_fall;

  assign w_lines = {PS2D, PS2C};

  // Idle bus level is high, so the conditioning chain resets to 1 to avoid a
  // phantom falling edge right after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_meta <= 2'b11;
      r_sync <= 2'b11;
      r_filt <= 2'b11;
      r_fall <= 1'b0;
      // NOTE: this small counter array is reset like any other register because it is logic, not a RAM; real memories would be left unreset.
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
      r_meta <= w_lines;
      r_sync <= r_meta;
      r_fall <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FLT_LAST) begin
          r_fcnt[i] <= '0;
          r_filt[i] <= r_sync[i];
          if (i == 0 && !r_sync[i]) r_fall <= 1'b1;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_frame;
  logic          r_ps2c_low;
  logic          r_ps2d_low;
  logic          r_busy;
  logic          r_tx_done;
  logic [1:0]    r_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_frame    <= '0;
      r_ps2c_low <= 1'b0;
      r_ps2d_low <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
      r_err      <= 2'b00;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ps2c_low <= 1'b0;
          r_ps2d_low <= 1'b0;
          // busy still set here means this is the tx_done cycle; requests are dropped.
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (wr_en) begin
            r_frame    <= {1'b1, ~^wr_data, wr_data};
            r_err      <= 2'b00;
            r_busy     <= 1'b1;
            r_ps2c_low <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            r_cnt      <= '0;
            r_ps2d_low <= 1'b1;
            r_state    <= S_REQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_REQ: begin
          r_ps2c_low <= 1'b0;
          r_cnt      <= '0;
          r_bit_cnt  <= '0;
          r_state    <= S_SEND;
        end
        S_SEND, S_ACK: begin
          if (r_cnt == TO_LAST) begin
            r_ps2c_low <= 1'b0;
            r_ps2d_low <= 1'b0;
            r_err      <= 2'b01;
            r_tx_done  <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_fall) begin
              if (r_state == S_SEND) begin
                r_ps2d_low <= ~r_frame[r_bit_cnt];
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == 4'd9) r_state <= S_ACK;
              end else begin
                r_err   <= r_filt[1] ? 2'b10 : 2'b00;
                r_state <= S_WAIT_IDLE;
              end
            end
          end
        end
        S_WAIT_IDLE: begin
          if (r_filt == 2'b11) begin
            r_tx_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ps2c_low   = r_ps2c_low;
  assign ps2d_low   = r_ps2d_low;
  assign busy       = r_busy;
  assign rx_inhibit = r_busy;
  assign tx_done    = r_tx_done;
  assign err_code   = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while
// a tx_done monitor checks each completion against a queue of expected results.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int FLT  = 8;
  localparam int HALF = 40;

  typedef struct {
    logic [1:0]  err;
    logic        chk;
    logic [10:0] frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ps2c_low, ps2d_low, busy, rx_inhibit, tx_done;
  logic [1:0] err_code;
  logic       dev_c_low, dev_d_low;
  logic       w_ps2c, w_ps2d;

  logic [10:0] dev_frame;
  exp_t        exp_q[$];
  int          vectors  = 0;
  int          fails    = 0;
  int          done_cnt = 0;
  int          cyc      = 0;

  // Open-drain bus: either side pulling low wins.
  assign w_ps2c = ~(ps2c_low | dev_c_low);
  assign w_ps2d = ~(ps2d_low | dev_d_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FLT)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .PS2C      (w_ps2c),
    .PS2D      (w_ps2d),
    .ps2c_low  (ps2c_low),
    .ps2d_low  (ps2d_low),
    .busy      (busy),
    .rx_inhibit(rx_inhibit),
    .tx_done   (tx_done),
    .err_code  (err_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] err, input logic chk, input logic [10:0] fr);
    exp_q.push_back('{err, chk, fr});
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_within_bound", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_release();
    int n = 0;
    while (!(ps2c_low === 1'b0 && busy === 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("release_within_bound", 32'(n < 5000), 32'd1);
  endtask

  // Device model: waits for the request-to-send, then clocks 10 bits in
  // (sampling PS2D after each rising edge) and finally the ACK clock.
  task automatic dev_xfer(input bit ack, input bit glitch);
    int n = 0;
    dev_frame = 'x;
    while (!(ps2c_low === 1'b0 && ps2d_low === 1'b1) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("dev_saw_request", 32'(n < 20000), 32'd1);
    if (n >= 20000) return;
    dev_frame[0] = w_ps2d;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_frame[k+1] = w_ps2d;
      if (glitch) begin
        repeat (5) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF - 5) @(negedge clk);
      end
    end
    dev_d_low = ack;
    repeat (10) @(negedge clk);
    dev_c_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_c_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_d_low = 1'b0;
  endtask

  // Monitor: every tx_done pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_tx_done: got a tx_done pulse with err_code=%0d, expected none", err_code);
        end else begin
          e = exp_q.pop_front();
          check("err_code", 32'(err_code), 32'(e.err));
          check("busy_at_done", 32'(busy), 32'd1);
          check("rx_inhibit_at_done", 32'(rx_inhibit), 32'd1);
          check("lines_released_at_done", 32'({ps2c_low, ps2d_low}), 32'd0);
          if (e.chk) check("device_frame", 32'(dev_frame), 32'(e.frame));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails + 1);
    $fatal(1, "watchdog");
  end

  // Sampled frames, index 0 = start: {stop, parity, data[7:0], start}.
  localparam logic [10:0] FR_ED = 11'b1_1_11101101_0;
  localparam logic [10:0] FR_01 = 11'b1_0_00000001_0;
  localparam logic [10:0] FR_07 = 11'b1_0_00000111_0;
  localparam logic [10:0] FR_FF = 11'b1_1_11111111_0;
  localparam logic [10:0] FR_00 = 11'b1_1_00000000_0;
  localparam logic [10:0] FR_F3 = 11'b1_1_11110011_0;
  localparam logic [10:0] FR_A5 = 11'b1_1_10100101_0;
  localparam logic [10:0] FR_3C = 11'b1_1_00111100_0;

  logic [7:0]  par_data [4] = '{8'h01, 8'h07, 8'hFF, 8'h00};
  logic [10:0] par_frame[4] = '{FR_01, FR_07, FR_FF, FR_00};

  initial begin
    int ndone = 0;
    int c0, c1, n;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; dev_c_low = 1'b0; dev_d_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ps2c_low", 32'(ps2c_low), 32'd0);
    check("rst_ps2d_low", 32'(ps2d_low), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_inhibit", 32'(rx_inhibit), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal 0xED with request-to-send timing.
    push(2'b00, 1'b1, FR_ED);
    fork
      dev_xfer(1'b1, 1'b0);
      begin
        send(8'hED);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ps2c_low", 32'(ps2c_low), 32'd1);
        check("t1_ps2d_low", 32'(ps2d_low), 32'd0);
        check("t1_rx_inhibit", 32'(rx_inhibit), 32'd1);
        repeat (INH - 1) @(negedge clk);
        check("ps2d_low_before_req", 32'(ps2d_low), 32'd0);
        @(negedge clk);
        check("req_ps2d_low", 32'(ps2d_low), 32'd1);
        check("req_ps2c_low", 32'(ps2c_low), 32'd1);
        @(negedge clk);
        check("ps2c_released", 32'(ps2c_low), 32'd0);
        check("start_bit_held", 32'(ps2d_low), 32'd1);
      end
    join
    wait_done(++ndone);

    // Parity 0 and 1 cases.
    for (int i = 0; i < 4; i++) begin
      push(2'b00, 1'b1, par_frame[i]);
      fork
        dev_xfer(1'b1, 1'b0);
        send(par_data[i]);
      join
      wait_done(++ndone);
    end

    // No ACK from the device.
    push(2'b10, 1'b1, FR_F3);
    fork
      dev_xfer(1'b0, 1'b0);
      send(8'hF3);
    join
    wait_done(++ndone);

    // Glitches on PS2C during every high phase.
    push(2'b00, 1'b1, FR_A5);
    fork
      dev_xfer(1'b1, 1'b1);
      send(8'hA5);
    join
    wait_done(++ndone);

    // Second request mid-transfer must be ignored.
    push(2'b00, 1'b1, FR_3C);
    fork
      dev_xfer(1'b1, 1'b0);
      begin
        send(8'h3C);
        repeat (300) @(negedge clk);
        send(8'h55);
      end
    join
    wait_done(++ndone);

    // Request in the tx_done cycle must be ignored.
    push(2'b00, 1'b1, FR_07);
    fork
      dev_xfer(1'b1, 1'b0);
      send(8'h07);
    join
    n = 0;
    while (tx_done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen_for_coincident_wr", 32'(tx_done), 32'd1);
    wr_data = 8'h99;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    ndone++;
    check("busy_after_done", 32'(busy), 32'd0);
    check("no_restart_after_done", 32'(ps2c_low), 32'd0);
    repeat (3) @(negedge clk);

    // Device never clocks: timeout exactly TO cycles after release.
    push(2'b01, 1'b0, '0);
    send(8'h5A);
    wait_release();
    c0 = cyc;
    n  = 0;
    while (tx_done !== 1'b1 && n < 3 * TO) begin
      @(negedge clk);
      n++;
    end
    c1 = cyc;
    check("timeout_latency", 32'(c1 - c0), 32'(TO));
    @(negedge clk);
    ndone++;
    check("busy_after_timeout", 32'(busy), 32'd0);

    // Reset in SEND releases everything and produces no tx_done.
    send(8'hAA);
    wait_release();
    repeat (20) @(negedge clk);
    check("send_start_bit_driven", 32'(ps2d_low), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_send_ps2c_low", 32'(ps2c_low), 32'd0);
    check("rst_send_ps2d_low", 32'(ps2d_low), 32'd0);
    check("rst_send_busy", 32'(busy), 32'd0);
    check("rst_send_tx_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TO + 200) @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);
    check("done_count_total", 32'(done_cnt), 32'(ndone));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
